// File: rtl/core_lsu_align.sv
// Load/store alignment unit: splits misaligned accesses into two bus beats,
// lane-shifts store data and merges/extends load data for writeback.
module core_lsu_align #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [2:0]              req_op_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_err_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LO,
        S_WAIT_LO,
        S_REQ_HI,
        S_WAIT_HI,
        S_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic                      we_q, we_d;
    logic [OW-1:0]             off_q, off_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [2*NB-1:0]           be2_q, be2_d;
    logic [2*DATA_WIDTH-1:0]   wd2_q, wd2_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic [DATA_WIDTH-1:0]     hi_q, hi_d;
    logic                      err_q, err_d;
    logic                      split_q, split_d;

    logic [OW-1:0]             in_off;
    logic [OW-1:0]             amask;
    int                        sz;
    logic                      illegal;
    logic                      misal;
    logic                      split;
    logic [2*NB-1:0]           mask;
    logic [2*DATA_WIDTH-1:0]   wshift;
    logic [DATA_WIDTH-1:0]     w;
    logic [DATA_WIDTH-1:0]     ld;

    // Decode of the incoming request, only consumed on accept.
    always_comb begin
        in_off = req_addr_i[OW-1:0];
        sz     = 4;
        amask  = OW'(3);
        case (req_op_i[1:0])
            2'b00: begin
                sz    = 1;
                amask = '0;
            end
            2'b01: begin
                sz    = 2;
                amask = OW'(1);
            end
            default: begin
                sz    = 4;
                amask = OW'(3);
            end
        endcase
        if (req_we_i) begin
            illegal = (req_op_i >= 3'b011);
        end else begin
            illegal = (req_op_i == 3'b011) || (req_op_i[2:1] == 2'b11);
        end
        misal = |(in_off & amask);
        split = (int'(in_off) + sz) > NB;
        for (int i = 0; i < 2*NB; i++) begin
            mask[i] = (i >= int'(in_off)) && (i < int'(in_off) + sz);
        end
        wshift = {{DATA_WIDTH{1'b0}}, req_wdata_i} << {in_off, 3'b000};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        we_d    = we_q;
        off_d   = off_q;
        base_d  = base_q;
        be2_d   = be2_q;
        wd2_d   = wd2_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        split_d = split_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    we_d    = req_we_i;
                    off_d   = in_off;
                    base_d  = {req_addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                    be2_d   = mask;
                    wd2_d   = wshift;
                    lo_d    = '0;
                    hi_d    = '0;
                    split_d = split;
                    err_d   = illegal || (misal && !MISALIGN_EN);
                    state_d = err_d ? S_RESP : S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (data_gnt_i) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (data_rvalid_i) begin
                    lo_d    = data_rdata_i;
                    state_d = split_q ? S_REQ_HI : S_RESP;
                end
            end
            S_REQ_HI: begin
                if (data_gnt_i) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (data_rvalid_i) begin
                    hi_d    = data_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Merge both beats, then pick and extend the addressed bytes.
    always_comb begin
        w = DATA_WIDTH'({hi_q, lo_q} >> {off_q, 3'b000});
        case (op_q)
            3'b000:  ld = DATA_WIDTH'($signed(w[7:0]));
            3'b001:  ld = DATA_WIDTH'($signed(w[15:0]));
            3'b010:  ld = DATA_WIDTH'($signed(w[31:0]));
            3'b100:  ld = DATA_WIDTH'(w[7:0]);
            3'b101:  ld = DATA_WIDTH'(w[15:0]);
            default: ld = '0;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = '0;
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        unique case (state_q)
            S_IDLE: req_ready_o = 1'b1;
            S_REQ_LO: begin
                data_req_o   = 1'b1;
                data_addr_o  = base_q;
                data_we_o    = we_q;
                data_be_o    = be2_q[NB-1:0];
                data_wdata_o = wd2_q[DATA_WIDTH-1:0];
            end
            S_REQ_HI: begin
                data_req_o   = 1'b1;
                data_addr_o  = base_q + ADDR_WIDTH'(NB);
                data_we_o    = we_q;
                data_be_o    = be2_q[2*NB-1:NB];
                data_wdata_o = wd2_q[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                if (!err_q && !we_q) resp_rdata_o = ld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            base_q  <= '0;
            be2_q   <= '0;
            wd2_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            we_q    <= we_d;
            off_q   <= off_d;
            base_q  <= base_d;
            be2_q   <= be2_d;
            wd2_q   <= wd2_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            split_q <= split_d;
        end
    end

endmodule
